// File: rtl/barrett_reduce_1997.sv
// rtl/barrett_reduce_1997.sv - two-stage pipelined Barrett reducer, din_a mod Q
//
// Computes the canonical residue of an unsigned operand modulo a fixed prime
// Q (default 1997) using Barrett reduction with a precomputed reciprocal M.
// One operand per clock, two register stages, no backpressure.
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst       in   synchronous reset, active-high
//   in_valid  in   din_a carries an operand this cycle
//   din_a     in   operand x, unsigned, DIN_W bits, x < 2^(2K)
//   out_valid out  dout_r carries a result this cycle
//   dout_r    out  x mod Q, range 0..Q-1; holds its value while out_valid = 0

module barrett_reduce_1997 #(
    parameter int Q      = 1997,
    parameter int DIN_W  = 21,
    parameter int DOUT_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DIN_W-1:0]  din_a,
    output logic              out_valid,
    output logic [DOUT_W-1:0] dout_r
);

    localparam int K = DOUT_W;
    // Reciprocal scaled by 2^(2K); an elaboration-time constant, not hardware.
    localparam int M = (2 ** (2 * K)) / Q;
    // Full product width x * M.
    localparam int PW = DIN_W + 12;
    // Width of the quotient estimate t = (x * M) >> 2K.
    localparam int TW = PW - 2 * K;
    // Remainder working width: r < 3Q fits in K+2 bits.
    localparam int RW = K + 2;

    localparam logic [RW-1:0] Q_RW = RW'(Q);

    // ---------------- Stage 1: quotient estimate ----------------
    logic [TW-1:0] t_next;
    logic [TW-1:0] t_s1;
    // Only the low RW bits of x matter: the true remainder x - t*Q is below
    // 2^RW, so the subtraction can be carried out modulo 2^RW.
    logic [RW-1:0] x_s1;
    logic          v_s1;

    assign t_next = TW'((PW'(din_a) * PW'(M)) >> (2 * K));

    always_ff @(posedge clk) begin
        if (rst) begin
            v_s1 <= 1'b0;
            x_s1 <= '0;
            t_s1 <= '0;
        end else begin
            v_s1 <= in_valid;
            if (in_valid) begin
                x_s1 <= RW'(din_a);
                t_s1 <= t_next;
            end
        end
    end

    // ---------------- Stage 2: remainder and correction ----------------
    logic [RW-1:0] tq;
    logic [RW-1:0] r0;
    logic [RW-1:0] r1;
    logic [RW-1:0] r2;
    logic          sub1;
    logic          sub2;

    // Truncating multiply: only the low RW bits of t*Q are needed.
    assign tq   = RW'(t_s1) * Q_RW;
    assign r0   = x_s1 - tq;
    assign sub1 = (r0 >= Q_RW);
    assign r1   = sub1 ? (r0 - Q_RW) : r0;
    assign sub2 = (r1 >= Q_RW);
    assign r2   = sub2 ? (r1 - Q_RW) : r1;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            dout_r    <= '0;
        end else begin
            out_valid <= v_s1;
            if (v_s1) begin
                dout_r <= DOUT_W'(r2);
            end
        end
    end

endmodule

// File: tb/tb_barrett_reduce_1997.sv
// tb/tb_barrett_reduce_1997.sv - randomized self-checking bench for barrett_reduce_1997

module tb_barrett_reduce_1997;

    localparam int Q = 1997;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [20:0] din_a = '0;
    logic        out_valid;
    logic [10:0] dout_r;

    int n_checks = 0;
    int n_fail   = 0;
    int corr_cnt = 0;

    // Per-edge history of the applied inputs.
    logic hr[$];
    logic hv[$];
    int   hx[$];
    int   held = 0;

    barrett_reduce_1997 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .din_a     (din_a),
        .out_valid (out_valid),
        .dout_r    (dout_r)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, clock it, then compare outputs against the
    // timing model: the operand sampled at edge n-1 is visible after edge n,
    // provided neither edge saw reset.
    task automatic step(input logic r, input logic v, input int x, input string tag);
        int n;
        int ev;
        int ed;
        rst      = r;
        in_valid = v;
        din_a    = 21'(x);
        @(posedge clk);
        #1;
        hr.push_back(r);
        hv.push_back(v);
        hx.push_back(x);
        n = hr.size() - 1;
        if (r) begin
            ev   = 0;
            held = 0;
        end else if (n >= 1 && !hr[n-1] && hv[n-1]) begin
            ev   = 1;
            held = hx[n-1] % Q;
        end else begin
            ev = 0;
        end
        ed = held;
        check({tag, "_valid"}, int'(out_valid), ev);
        check({tag, "_dout"}, int'(dout_r), ed);
        if (v && !r && (x - ((x * 2100) / 4194304) * Q) >= Q)
            corr_cnt++;
    endtask

    initial begin
        int x;
        int base;

        // Reset held three cycles with in_valid high.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 500 + i, "reset");

        // Identity sweep 0..Q-1 back-to-back.
        for (int i = 0; i < Q; i++) step(1'b0, 1'b1, i, "ident");
        step(1'b0, 1'b0, 0, "ident_tail");
        step(1'b0, 1'b0, 0, "ident_tail");

        // Multiples and edges.
        step(1'b0, 1'b1, 1997, "edge");
        step(1'b0, 1'b1, 1998, "edge");
        step(1'b0, 1'b1, 3993, "edge");
        step(1'b0, 1'b1, 3994, "edge");
        step(1'b0, 1'b1, 2097151, "edge");
        step(1'b0, 1'b1, 0, "edge");
        step(1'b0, 1'b0, 0, "edge_tail");
        step(1'b0, 1'b0, 0, "edge_tail");

        // Full-range random with bubbles.
        for (int i = 0; i < 10000; i++) begin
            x = int'($urandom_range(0, 2097151));
            step(1'b0, ($urandom_range(0, 3) != 0), x, "rand");
        end

        // Mid-stream reset on the 5th operand.
        for (int i = 0; i < 11; i++) step((i == 4), 1'b1, 1000 + i, "midrst");
        step(1'b0, 1'b0, 0, "midrst_tail");
        step(1'b0, 1'b0, 0, "midrst_tail");

        // Top 4096 values of the input range.
        for (int i = 0; i < 4096; i++) step(1'b0, 1'b1, 2097151 - i, "top");

        // Values around random multiples of Q.
        for (int i = 0; i < 200; i++) begin
            base = int'($urandom_range(1, 1050)) * Q;
            for (int d = -2; d <= 2; d++) begin
                x = base + d;
                if (x > 2097151) x = 2097151;
                step(1'b0, 1'b1, x, "nearq");
            end
        end
        step(1'b0, 1'b0, 0, "final_tail");
        step(1'b0, 1'b0, 0, "final_tail");

        // The remainder-correction path must have been exercised.
        check("corr_seen", int'(corr_cnt > 0), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Range guard on every valid result.
    always @(negedge clk) begin
        if (hr.size() > 3 && out_valid === 1'b1)
            check("range", int'(dout_r < 11'(Q)), 1);
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
